// File: rtl/mcmem_pkg.sv
// mcmem_pkg -- shared types and constants for the mcmem_resp memory responder.
//   state_t  : responder FSM states (IDLE -> WAIT -> RESP -> IDLE)
//   WORD_W   : data word width
//   WAIT_MAX : largest supported WAIT parameter, sets the wait counter width
package mcmem_pkg;

   localparam int WORD_W   = 32;
   localparam int WAIT_MAX = 15;
   localparam int CNT_W    = $clog2(WAIT_MAX + 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_WAIT = 2'd1,
      S_RESP = 2'd2
   } state_t;

endpackage

// File: rtl/mcmem_ram.sv
// mcmem_ram -- single-port word memory, synchronous write, registered read.
//   clk   : clock
//   clrn  : synchronous active-low reset, clears only the read register
//   en    : access strobe (one cycle)
//   we    : 1 = write wdata to mem[addr], 0 = read mem[addr] into rdata
//   rclr  : on a read access, load rdata with zero instead of the memory word
//   addr  : word index
//   wdata : write data
//   rdata : registered read data, holds until the next read access
module mcmem_ram
   import mcmem_pkg::*;
#(
   parameter int ADDR_W = 8
) (
   input  logic              clk,
   input  logic              clrn,
   input  logic              en,
   input  logic              we,
   input  logic              rclr,
   input  logic [ADDR_W-1:0] addr,
   input  logic [WORD_W-1:0] wdata,
   output logic [WORD_W-1:0] rdata
);

   logic [WORD_W-1:0] mem [2**ADDR_W];

   // Storage is never reset; contents survive clrn.
   always_ff @(posedge clk) begin
      if (en && we) mem[addr] <= wdata;
   end

   always_ff @(posedge clk) begin
      if (!clrn)            rdata <= '0;
      else if (en && !we)   rdata <= rclr ? '0 : mem[addr];
   end

endmodule

// File: rtl/mcmem_resp.sv
// mcmem_resp -- CPU-side memory responder with a fixed number of wait cycles.
// A request is accepted only in IDLE; address, data and direction are latched,
// WAIT cycles elapse, then RESP pulses ready for one cycle.
//   clk   : clock
//   clrn  : synchronous active-low reset (aborts any transaction in flight)
//   req   : request strobe, sampled only in IDLE
//   wmem  : 1 = write, 0 = read
//   adr   : byte address; word index is adr[ADDR_W+1:2], higher bits ignored
//   tom   : write data
//   fromm : registered read data
//   ready : one-cycle response strobe
//   busy  : high whenever not IDLE
//   err   : misaligned-access flag, meaningful only with ready
// Optional feature: define MCMEM_ALIGN_CHECK_EN to flag adr[1:0]!=0 as an
// error (write suppressed, fromm loaded with zero). Otherwise err is tied low.
module mcmem_resp
   import mcmem_pkg::*;
#(
   parameter int ADDR_W = 8,
   parameter int WAIT   = 2
) (
   input  logic        clk,
   input  logic        clrn,
   input  logic        req,
   input  logic        wmem,
   input  logic [31:0] adr,
   input  logic [31:0] tom,
   output logic [31:0] fromm,
   output logic        ready,
   output logic        busy,
   output logic        err
);

   localparam logic [CNT_W-1:0] CNT_INIT = (WAIT > 0) ? CNT_W'(WAIT - 1) : '0;

   state_t            state_q, state_n;
   logic [CNT_W-1:0]  cnt_q;
   logic [ADDR_W-1:0] idx_q;
   logic [WORD_W-1:0] tom_q;
   logic              wmem_q;

   logic              accept;
   logic              rsp_go;
   logic [ADDR_W-1:0] cur_idx;
   logic [WORD_W-1:0] cur_tom;
   logic              cur_wmem;
   logic              cur_bad;

   assign accept = (state_q == S_IDLE) && req;

   // ---- state register ----
   always_ff @(posedge clk) begin
      if (!clrn) state_q <= S_IDLE;
      else       state_q <= state_n;
   end

   // ---- next state ----
   always_comb begin
      state_n = state_q;
      case (state_q)
         S_IDLE:  if (req) state_n = (WAIT > 0) ? S_WAIT : S_RESP;
         S_WAIT:  if (cnt_q == '0) state_n = S_RESP;
         S_RESP:  state_n = S_IDLE;
         default: state_n = S_IDLE;
      endcase
   end

   // ---- outputs ----
   always_comb begin
      busy  = (state_q != S_IDLE);
      ready = (state_q == S_RESP);
   end

   // ---- wait counter and request latches ----
   always_ff @(posedge clk) begin
      if (!clrn) begin
         cnt_q  <= '0;
         idx_q  <= '0;
         tom_q  <= '0;
         wmem_q <= 1'b0;
      end else if (accept) begin
         cnt_q  <= CNT_INIT;
         idx_q  <= adr[ADDR_W+1:2];
         tom_q  <= tom;
         wmem_q <= wmem;
      end else if (state_q == S_WAIT && cnt_q != '0) begin
         cnt_q  <= cnt_q - 1'b1;
      end
   end

   // With WAIT=0 the RAM access happens on the accepting edge itself, before
   // the latches hold the request, so the live inputs are used in IDLE.
   assign cur_idx  = (state_q == S_IDLE) ? adr[ADDR_W+1:2] : idx_q;
   assign cur_tom  = (state_q == S_IDLE) ? tom             : tom_q;
   assign cur_wmem = (state_q == S_IDLE) ? wmem            : wmem_q;

`ifdef MCMEM_ALIGN_CHECK_EN
   logic mis_q;

   always_ff @(posedge clk) begin
      if (!clrn)       mis_q <= 1'b0;
      else if (accept) mis_q <= (adr[1:0] != 2'b00);
   end

   assign cur_bad = (state_q == S_IDLE) ? (adr[1:0] != 2'b00) : mis_q;
   assign err     = ready && mis_q;
`else
   logic unused_lsb;
   assign unused_lsb = ^adr[1:0];
   assign cur_bad    = 1'b0;
   assign err        = 1'b0;
`endif

   logic unused_hi;
   assign unused_hi = ^adr[31:ADDR_W+2];

   // Memory access fires on the edge entering RESP; gating with clrn keeps a
   // reset on that same edge from completing an aborted write.
   assign rsp_go = clrn && (state_n == S_RESP) && (state_q != S_RESP);

   mcmem_ram #(.ADDR_W(ADDR_W)) u_ram (
      .clk   (clk),
      .clrn  (clrn),
      .en    (rsp_go),
      .we    (cur_wmem && !cur_bad),
      .rclr  (cur_bad),
      .addr  (cur_idx),
      .wdata (cur_tom),
      .rdata (fromm)
   );

endmodule

// File: tb/tb_mcmem_resp.sv
// Bench: instance 0 runs WAIT=2, instance 1 runs WAIT=0, both ADDR_W=8.
module tb_mcmem_resp;

`ifdef MCMEM_ALIGN_CHECK_EN
   localparam bit ALIGN = 1'b1;
`else
   localparam bit ALIGN = 1'b0;
`endif

   logic        clk;
   logic        clrn  [2];
   logic        req   [2];
   logic        wmem  [2];
   logic [31:0] adr   [2];
   logic [31:0] tom   [2];
   logic [31:0] fromm [2];
   logic        ready [2];
   logic        busy  [2];
   logic        err   [2];

   int nvec = 0;
   int nerr = 0;

   mcmem_resp #(.ADDR_W(8), .WAIT(2)) u_w2 (
      .clk(clk), .clrn(clrn[0]), .req(req[0]), .wmem(wmem[0]), .adr(adr[0]),
      .tom(tom[0]), .fromm(fromm[0]), .ready(ready[0]), .busy(busy[0]), .err(err[0]));

   mcmem_resp #(.ADDR_W(8), .WAIT(0)) u_w0 (
      .clk(clk), .clrn(clrn[1]), .req(req[1]), .wmem(wmem[1]), .adr(adr[1]),
      .tom(tom[1]), .fromm(fromm[1]), .ready(ready[1]), .busy(busy[1]), .err(err[1]));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        wm;
      logic [31:0] a;
      logic [31:0] t;
      logic [31:0] ef;
      logic        ee;
   } vec_t;

   vec_t tbl [10];

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
      nvec++;
      if (got !== exp) begin
         nerr++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", nm, got, exp);
      end
   endtask

   // One transaction: drive at a falling edge, then watch falling edges for ready.
   task automatic txn(input int d, input logic wm, input logic [31:0] a, input logic [31:0] t,
                      output int lat, output logic [31:0] f, output logic e, output logic b1);
      @(negedge clk);
      req[d] = 1'b1; wmem[d] = wm; adr[d] = a; tom[d] = t;
      lat = -1; f = 'x; e = 1'bx; b1 = 1'b0;
      for (int i = 1; i <= 20; i++) begin
         @(negedge clk);
         if (i == 1) b1 = busy[d];
         if (ready[d]) begin
            lat = i; f = fromm[d]; e = err[d];
            break;
         end
      end
      req[d] = 1'b0;
   endtask

   initial begin
      int          lat;
      logic [31:0] f;
      logic        e, b1;
      logic [31:0] exp8;
      int          nrdy;

      exp8 = ALIGN ? 32'hAAAA5555 : 32'h0BADF00D;
      tbl[0] = '{1'b1, 32'h0000_0010, 32'hDEADBEEF, 32'h0000_0000, 1'b0};
      tbl[1] = '{1'b0, 32'h0000_0010, 32'h0,        32'hDEADBEEF, 1'b0};
      tbl[2] = '{1'b1, 32'h0000_0400, 32'h0000_1234, 32'hDEADBEEF, 1'b0};
      tbl[3] = '{1'b0, 32'h0000_0000, 32'h0,        32'h0000_1234, 1'b0};
      tbl[4] = '{1'b1, 32'h0000_0020, 32'hAAAA5555, 32'h0000_1234, 1'b0};
      tbl[5] = '{1'b0, 32'h0000_0020, 32'h0,        32'hAAAA5555, 1'b0};
      tbl[6] = '{1'b1, 32'h0000_0022, 32'h0BADF00D, ALIGN ? 32'h0 : 32'hAAAA5555, ALIGN};
      tbl[7] = '{1'b0, 32'h0000_0020, 32'h0,        exp8,         1'b0};
      tbl[8] = '{1'b1, 32'h0000_03FC, 32'h1111_1111, exp8,        1'b0};
      tbl[9] = '{1'b0, 32'h0000_0FFC, 32'h0,        32'h1111_1111, 1'b0};

      for (int d = 0; d < 2; d++) begin
         clrn[d] = 1'b0; req[d] = 1'b0; wmem[d] = 1'b0; adr[d] = '0; tom[d] = '0;
      end
      repeat (3) @(negedge clk);
      for (int d = 0; d < 2; d++) begin
         chk($sformatf("rst fromm[%0d]", d), fromm[d], 32'h0);
         chk($sformatf("rst ready[%0d]", d), 32'(ready[d]), 32'h0);
         chk($sformatf("rst busy[%0d]", d), 32'(busy[d]), 32'h0);
         chk($sformatf("rst err[%0d]", d), 32'(err[d]), 32'h0);
      end
      clrn[0] = 1'b1; clrn[1] = 1'b1;

      // ---- table on WAIT=2 ----
      for (int i = 0; i < 10; i++) begin
         txn(0, tbl[i].wm, tbl[i].a, tbl[i].t, lat, f, e, b1);
         chk($sformatf("v%0d latency", i), 32'(lat), 32'd3);
         chk($sformatf("v%0d busy", i), 32'(b1), 32'd1);
         chk($sformatf("v%0d fromm", i), f, tbl[i].ef);
         chk($sformatf("v%0d err", i), 32'(e), 32'(tbl[i].ee));
      end

      // ---- reset on the edge that would enter RESP of a write to 0x20 ----
      @(negedge clk);
      req[0] = 1'b1; wmem[0] = 1'b1; adr[0] = 32'h20; tom[0] = 32'h5555_5555;
      @(negedge clk);
      req[0] = 1'b0;
      chk("abort busy in wait", 32'(busy[0]), 32'd1);
      @(negedge clk);
      clrn[0] = 1'b0;
      @(negedge clk);
      chk("abort ready", 32'(ready[0]), 32'd0);
      chk("abort busy", 32'(busy[0]), 32'd0);
      clrn[0] = 1'b1;
      nrdy = 0;
      repeat (4) begin
         @(negedge clk);
         if (ready[0]) nrdy++;
      end
      chk("abort no ready", 32'(nrdy), 32'd0);

      // ---- req/adr changes during WAIT are ignored ----
      @(negedge clk);
      req[0] = 1'b1; wmem[0] = 1'b0; adr[0] = 32'h10;
      @(negedge clk);
      req[0] = 1'b0; wmem[0] = 1'b1; adr[0] = 32'h20; tom[0] = 32'hFFFF_FFFF;
      @(negedge clk);
      req[0] = 1'b1;
      @(negedge clk);
      chk("ign ready", 32'(ready[0]), 32'd1);
      chk("ign fromm", fromm[0], 32'hDEADBEEF);
      req[0] = 1'b0;
      @(negedge clk);
      chk("ign ready drop", 32'(ready[0]), 32'd0);

      txn(0, 1'b0, 32'h20, 32'h0, lat, f, e, b1);
      chk("old word8 latency", 32'(lat), 32'd3);
      chk("old word8 fromm", f, exp8);

      // ---- WAIT=0: preload word 5, reset, read it back ----
      txn(1, 1'b1, 32'h14, 32'hC0FFEE05, lat, f, e, b1);
      chk("w0 write latency", 32'(lat), 32'd1);
      @(negedge clk);
      clrn[1] = 1'b0;
      repeat (2) @(negedge clk);
      chk("w0 rst fromm", fromm[1], 32'h0);
      clrn[1] = 1'b1;
      txn(1, 1'b0, 32'h14, 32'h0, lat, f, e, b1);
      chk("w0 read latency", 32'(lat), 32'd1);
      chk("w0 read fromm", f, 32'hC0FFEE05);

      // ---- WAIT=0 back-to-back: ready every other cycle ----
      @(negedge clk);
      req[1] = 1'b1; wmem[1] = 1'b0; adr[1] = 32'h14;
      for (int i = 1; i <= 8; i++) begin
         @(negedge clk);
         chk($sformatf("b2b ready c%0d", i), 32'(ready[1]), 32'(i % 2));
      end
      req[1] = 1'b0;
      @(negedge clk);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule

// File: doc/mcmem_resp.md
MCMEM_RESP -- requirements
Module: mcmem_resp

Interface
REQ-001 Parameter ADDR_W, default 8, word-address width; memory depth SHALL be 2**ADDR_W 32-bit words.
REQ-002 Parameter WAIT, default 2, range 0..15, wait cycles inserted before each response.
REQ-003 clk  input  1  single clock; all state SHALL update on the rising edge.
REQ-004 clrn  input  1  reset, synchronous, active-low.
REQ-005 req  input  1  CPU request strobe, sampled only in IDLE.
REQ-006 wmem  input  1  1 = write, 0 = read; qualified by req.
REQ-007 adr  input  32  byte address from the CPU.
REQ-008 tom  input  32  write data from the CPU.
REQ-009 fromm  output  32  read data, registered.
REQ-010 ready  output  1  one-cycle response strobe.
REQ-011 busy  output  1  high in every state except IDLE.
REQ-012 err  output  1  misalignment flag, valid only while ready=1.

Function
REQ-013 FSM states SHALL be IDLE, WAIT and RESP.
REQ-014 IDLE with req=1 SHALL latch adr, tom and wmem.
  - Next state SHALL be WAIT, loading the wait counter with WAIT-1, when WAIT>0.
  - Next state SHALL be RESP when WAIT=0.
REQ-015 WAIT SHALL decrement the counter each cycle and SHALL move to RESP on the cycle the counter is 0.
REQ-016 RESP SHALL last exactly one cycle, drive ready=1, then return to IDLE.
REQ-017 Latency: a req sampled at edge k SHALL produce ready=1 in the cycle after edge k+WAIT+1.
REQ-018 Throughput: at most one transaction per WAIT+2 cycles.
  - req in WAIT or RESP SHALL be ignored, not queued.
  - The CPU SHALL hold req until it sees ready.
REQ-019 Word index SHALL be latched adr[ADDR_W+1:2]; higher address bits SHALL be ignored, so accesses wrap modulo depth.
REQ-020 Read: fromm SHALL be loaded with mem[index] on the edge entering RESP, and SHALL hold that value until the next RESP.
REQ-021 Write: mem[index] SHALL be written with the latched tom on the edge entering RESP; fromm SHALL be unchanged.
REQ-022 A read issued immediately after a write to the same word SHALL return the newly written data.
REQ-023 Input changes on adr, tom or wmem after latching SHALL NOT affect the transaction in flight.

Reset
REQ-024 clrn=0 at a rising edge SHALL force IDLE, fromm=0, ready=0, busy=0, err=0, counter=0.
REQ-025 Reset mid-transaction SHALL abort it: a pending write SHALL NOT be performed and no ready SHALL be issued.
REQ-026 Reset SHALL NOT clear memory contents.

Configuration
REQ-027 With MCMEM_ALIGN_CHECK_EN defined, a latched adr[1:0]≠0 SHALL give err=1 with ready, suppress any write, and load fromm=0.
REQ-028 Without MCMEM_ALIGN_CHECK_EN, adr[1:0] SHALL be ignored and err SHALL be tied to 0.

Structure
REQ-029 Package mcmem_pkg SHALL hold the state enum typedef, WORD_W=32 and WAIT_MAX=15.
REQ-030 Storage SHALL be a sub-module mcmem_ram (synchronous write, registered read, one port).
  - mcmem_resp SHALL contain the FSM, the counter and the request latches.

Verification
REQ-031 WAIT=2: write adr=0x10, tom=0xDEADBEEF, then read adr=0x10 -> ready 3 cycles after each req edge, fromm=0xDEADBEEF.
REQ-032 WAIT=0: read after reset of a preloaded word 5 -> ready in the cycle after the req edge; back-to-back reqs -> one response per 2 cycles.
REQ-033 ADDR_W=8: write adr=0x400 with 0x1234 -> read adr=0x000 returns 0x1234 (wrap).
REQ-034 clrn=0 during WAIT of a write to adr=0x20 -> no ready, busy=0; a later read of 0x20 returns the old value.
REQ-035 MCMEM_ALIGN_CHECK_EN defined, write adr=0x22 -> ready=1, err=1, word 8 unchanged; undefined -> word 8 written, err=0.
REQ-036 req toggled during WAIT with a different adr -> ignored; the original transaction completes unchanged.
